// File: rtl/z_result_serializer_if.sv
// Handshake bundle between the ALU result producer, the serializer and the internal bus.
interface z_result_serializer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    z_valid;
  logic                    z_ready;
  logic [2*DATA_WIDTH-1:0] ZData;
  logic                    z_wide;
  logic                    bus_valid;
  logic                    bus_ready;
  logic [DATA_WIDTH-1:0]   bus_data;
  logic                    bus_hi;
  logic [DATA_WIDTH-1:0]   RZLo;
  logic [DATA_WIDTH-1:0]   RZHi;

  modport master (
    output z_valid, ZData, z_wide, bus_ready,
    input  z_ready, bus_valid, bus_data, bus_hi, RZLo, RZHi
  );

  modport slave (
    input  z_valid, ZData, z_wide, bus_ready,
    output z_ready, bus_valid, bus_data, bus_hi, RZLo, RZHi
  );
endinterface

// File: rtl/z_result_serializer.sv
// Queues 64-bit ALU results and emits them as Lo (narrow) or Lo,Hi (wide) beats on a 32-bit bus.
// Latency 2 edges from push to first beat; bus stalls hold the beat and fill the FIFO until z_ready drops.
module z_result_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                 clock,
  input  logic                 clear,
  z_result_serializer_if.slave zif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic                    wide;
    logic [2*DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  entry_t                mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]         count;
  state_t                state;
  entry_t                head, next_head, in_entry;
  logic                  push, pop, more;
  logic                  bus_valid_q, bus_hi_q;
  logic [DATA_WIDTH-1:0] bus_data_q, rz_lo_q, rz_hi_q;

  assign zif.z_ready = (count < CW'(DEPTH));
  assign push        = zif.z_valid & zif.z_ready;
  assign in_entry    = '{wide: zif.z_wide, data: zif.ZData};
  assign head        = mem[rd_ptr];
  assign rd_ptr_nxt  = rd_ptr + 1'b1;

  // The entry under transfer is popped only on its final beat.
  assign pop  = zif.bus_ready & (((state == SEND_LO) & ~head.wide) | (state == SEND_HI));
  assign more = (count > CW'(1)) | push;
  // When the popped head was the only entry, the follow-on head is the one arriving now.
  assign next_head = (count == CW'(1)) ? in_entry : mem[rd_ptr_nxt];

  assign zif.bus_valid = bus_valid_q;
  assign zif.bus_data  = bus_data_q;
  assign zif.bus_hi    = bus_hi_q;
  assign zif.RZLo      = rz_lo_q;
  assign zif.RZHi      = rz_hi_q;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      bus_valid_q <= 1'b0;
      bus_hi_q    <= 1'b0;
      bus_data_q  <= '0;
      rz_lo_q     <= '0;
      rz_hi_q     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_nxt;
      count <= count + CW'(push) - CW'(pop);

      case (state)
        IDLE: begin
          if (count != '0) begin
            state       <= SEND_LO;
            bus_valid_q <= 1'b1;
            bus_data_q  <= head.data[DATA_WIDTH-1:0];
            bus_hi_q    <= 1'b0;
          end
        end
        SEND_LO: begin
          if (zif.bus_ready) begin
            rz_lo_q <= head.data[DATA_WIDTH-1:0];
            if (head.wide) begin
              state      <= SEND_HI;
              bus_data_q <= head.data[2*DATA_WIDTH-1:DATA_WIDTH];
              bus_hi_q   <= 1'b1;
            end else begin
              rz_hi_q     <= '0;
              state       <= more ? SEND_LO : IDLE;
              bus_valid_q <= more;
              bus_data_q  <= more ? next_head.data[DATA_WIDTH-1:0] : '0;
              bus_hi_q    <= 1'b0;
            end
          end
        end
        SEND_HI: begin
          if (zif.bus_ready) begin
            rz_hi_q     <= head.data[2*DATA_WIDTH-1:DATA_WIDTH];
            state       <= more ? SEND_LO : IDLE;
            bus_valid_q <= more;
            bus_data_q  <= more ? next_head.data[DATA_WIDTH-1:0] : '0;
            bus_hi_q    <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          bus_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_z_result_serializer.sv
// Cycle-by-cycle vector table for z_result_serializer plus hand-written latency/stall sequences.
module tb_z_result_serializer;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic clear;

  z_result_serializer_if #(.DATA_WIDTH(DW)) zif ();

  z_result_serializer #(.DATA_WIDTH(DW), .DEPTH(2)) dut (
    .clock (clock),
    .clear (clear),
    .zif   (zif)
  );

  always #5 clock = ~clock;

  // Inputs are driven before an edge; expectations are the outputs just after that edge.
  typedef struct {
    logic        clr;
    logic        zv;
    logic        zw;
    logic [63:0] zd;
    logic        br;
    logic        zr;
    logic        bv;
    logic [31:0] bd;
    logic        bh;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vt[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic clr, input logic zv, input logic zw, input logic [63:0] zd,
                              input logic br, input logic zr, input logic bv, input logic [31:0] bd,
                              input logic bh, input logic [31:0] lo, input logic [31:0] hi);
    vec_t v;
    v.clr = clr; v.zv = zv; v.zw = zw; v.zd = zd; v.br = br;
    v.zr = zr; v.bv = bv; v.bd = bd; v.bh = bh; v.lo = lo; v.hi = hi;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    clear = 1'b1;
    zif.z_valid = 1'b0;
    zif.z_wide = 1'b0;
    zif.ZData = '0;
    zif.bus_ready = 1'b0;

    //            clr zv zw zd                      br   zr bv bd            bh lo            hi
    // reset
    vt.push_back(mk(1, 0, 0, 64'h0,                  0,   1, 0, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(mk(1, 0, 0, 64'h0,                  0,   1, 0, 32'h0,        0, 32'h0,        32'h0));
    // narrow result
    vt.push_back(mk(0, 1, 0, 64'h7,                  1,   1, 0, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  1,   1, 1, 32'h7,        0, 32'h0,        32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  1,   1, 0, 32'h0,        0, 32'h7,        32'h0));
    // wide result with a 3-cycle stall
    vt.push_back(mk(0, 1, 1, 64'hDEADBEEF_12345678,  0,   1, 0, 32'h0,        0, 32'h7,        32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  0,   1, 1, 32'h12345678, 0, 32'h7,        32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  0,   1, 1, 32'h12345678, 0, 32'h7,        32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  0,   1, 1, 32'h12345678, 0, 32'h7,        32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  0,   1, 1, 32'h12345678, 0, 32'h7,        32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  1,   1, 1, 32'hDEADBEEF, 1, 32'h12345678, 32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  1,   1, 0, 32'h0,        0, 32'h12345678, 32'hDEADBEEF));
    // full FIFO: third push waits, refused even on the popping cycle
    vt.push_back(mk(0, 1, 0, 64'h11111111_AAAA0001,  0,   1, 0, 32'h0,        0, 32'h12345678, 32'hDEADBEEF));
    vt.push_back(mk(0, 1, 1, 64'hBBBB0002_BBBB0001,  0,   0, 1, 32'hAAAA0001, 0, 32'h12345678, 32'hDEADBEEF));
    vt.push_back(mk(0, 1, 0, 64'h00000000_CCCC0001,  0,   0, 1, 32'hAAAA0001, 0, 32'h12345678, 32'hDEADBEEF));
    vt.push_back(mk(0, 1, 0, 64'h00000000_CCCC0001,  0,   0, 1, 32'hAAAA0001, 0, 32'h12345678, 32'hDEADBEEF));
    vt.push_back(mk(0, 1, 0, 64'h00000000_CCCC0001,  1,   1, 1, 32'hBBBB0001, 0, 32'hAAAA0001, 32'h0));
    vt.push_back(mk(0, 1, 0, 64'h00000000_CCCC0001,  1,   0, 1, 32'hBBBB0002, 1, 32'hBBBB0001, 32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  1,   1, 1, 32'hCCCC0001, 0, 32'hBBBB0001, 32'hBBBB0002));
    vt.push_back(mk(0, 0, 0, 64'h0,                  1,   1, 0, 32'h0,        0, 32'hCCCC0001, 32'h0));
    // reset while in SEND_HI with two entries queued
    vt.push_back(mk(0, 1, 1, 64'h0D0D0D0D_D0D0D0D0,  0,   1, 0, 32'h0,        0, 32'hCCCC0001, 32'h0));
    vt.push_back(mk(0, 1, 0, 64'h00000000_00000E0E,  0,   0, 1, 32'hD0D0D0D0, 0, 32'hCCCC0001, 32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  1,   0, 1, 32'h0D0D0D0D, 1, 32'hD0D0D0D0, 32'h0));
    vt.push_back(mk(1, 0, 0, 64'h0,                  0,   1, 0, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  1,   1, 0, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  1,   1, 0, 32'h0,        0, 32'h0,        32'h0));
    // back-to-back wide/narrow/wide with bus_ready held high
    vt.push_back(mk(0, 1, 1, 64'h6A6A0002_6A6A0001,  1,   1, 0, 32'h0,        0, 32'h0,        32'h0));
    vt.push_back(mk(0, 1, 0, 64'h00000000_6B6B0001,  1,   0, 1, 32'h6A6A0001, 0, 32'h0,        32'h0));
    vt.push_back(mk(0, 1, 1, 64'h6C6C0002_6C6C0001,  1,   0, 1, 32'h6A6A0002, 1, 32'h6A6A0001, 32'h0));
    vt.push_back(mk(0, 1, 1, 64'h6C6C0002_6C6C0001,  1,   1, 1, 32'h6B6B0001, 0, 32'h6A6A0001, 32'h6A6A0002));
    vt.push_back(mk(0, 1, 1, 64'h6C6C0002_6C6C0001,  1,   1, 1, 32'h6C6C0001, 0, 32'h6B6B0001, 32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  1,   1, 1, 32'h6C6C0002, 1, 32'h6C6C0001, 32'h0));
    vt.push_back(mk(0, 0, 0, 64'h0,                  1,   1, 0, 32'h0,        0, 32'h6C6C0001, 32'h6C6C0002));

    foreach (vt[i]) begin
      clear         = vt[i].clr;
      zif.z_valid   = vt[i].zv;
      zif.z_wide    = vt[i].zw;
      zif.ZData     = vt[i].zd;
      zif.bus_ready = vt[i].br;
      tick();
      check($sformatf("row%0d z_ready", i),   64'(zif.z_ready),   64'(vt[i].zr));
      check($sformatf("row%0d bus_valid", i), 64'(zif.bus_valid), 64'(vt[i].bv));
      if (vt[i].bv || vt[i].clr) begin
        check($sformatf("row%0d bus_data", i), 64'(zif.bus_data), 64'(vt[i].bd));
        check($sformatf("row%0d bus_hi", i),   64'(zif.bus_hi),   64'(vt[i].bh));
      end
      check($sformatf("row%0d RZLo", i), 64'(zif.RZLo), 64'(vt[i].lo));
      check($sformatf("row%0d RZHi", i), 64'(zif.RZHi), 64'(vt[i].hi));
    end

    // Latency from an empty, idle FIFO, then a longer stall on a wide result.
    clear = 1'b0;
    zif.z_valid = 1'b1;
    zif.z_wide = 1'b1;
    zif.ZData = 64'h5555AAAA_3333CCCC;
    zif.bus_ready = 1'b0;
    tick();
    zif.z_valid = 1'b0;
    check("no_bypass bus_valid", 64'(zif.bus_valid), 64'h0);
    n = 0;
    while (!zif.bus_valid && n < 8) begin
      tick();
      n++;
    end
    check("first_beat_latency", 64'(n), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("stall%0d bus_valid", k), 64'(zif.bus_valid), 64'h1);
      check($sformatf("stall%0d bus_data", k),  64'(zif.bus_data),  64'h3333CCCC);
      check($sformatf("stall%0d bus_hi", k),    64'(zif.bus_hi),    64'h0);
    end
    zif.bus_ready = 1'b1;
    tick();
    check("stall_hi bus_data", 64'(zif.bus_data), 64'h5555AAAA);
    check("stall_hi bus_hi",   64'(zif.bus_hi),   64'h1);
    check("stall_hi RZLo",     64'(zif.RZLo),     64'h3333CCCC);
    check("stall_hi RZHi",     64'(zif.RZHi),     64'h6C6C0002);
    tick();
    check("stall_done bus_valid", 64'(zif.bus_valid), 64'h0);
    check("stall_done RZHi",      64'(zif.RZHi),      64'h5555AAAA);
    zif.bus_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
